ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: BUF_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported).
REQ-003 SHALL have port: clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  synchronous active-low reset (0 = reset, sampled on posedge clk).
REQ-005 SHALL have port: validPC  output  1  fetch request to instruction memory.
REQ-006 SHALL have port: pc  output  32  fetch address, meaningful when validPC=1.
REQ-007 SHALL have port: validInst  input  1  memory response valid, exactly one cycle after the accepted request.
REQ-008 SHALL have port: inst  input  32  instruction word, meaningful when validInst=1.
REQ-009 SHALL have ports: out_valid output 1, out_ready input 1, out_pc output 32, out_inst output 32; these form the valid/ready channel to decode.
REQ-010 SHALL have ports: redirect_valid input 1, redirect_pc input 32; this is a branch/jump/trap redirect from downstream.
REQ-011 SHALL have port: fetch_fault  output  1  misaligned-redirect fault flag (see Configuration).

Function
REQ-012 FSM states SHALL be BOOT, RUN and FAULT; BOOT lasts exactly one cycle after rst rises, then the FSM moves to RUN.
REQ-013 Memory has no backpressure, so the block SHALL issue only when the response is guaranteed buffer space: validPC = (state==RUN) & ~redirect_valid & (count + inflight - pop < 2), where pop = out_valid & out_ready.
REQ-014 On issue, the issued pc SHALL be latched into rsp_pc, inflight<=1, and pc<=pc+4 (mod 2^32 wrap, 32'hFFFF_FFFC -> 0); with no issue, inflight<=0 and pc SHALL hold.
REQ-015 When validInst=1 and inflight=1 and ~redirect_valid, {rsp_pc, inst} SHALL be pushed into the FIFO that same cycle; validInst with inflight=0 SHALL be ignored.
REQ-016 out_valid SHALL equal (count!=0); out_pc/out_inst SHALL come from the FIFO head; no combinational path from validInst to out_valid (minimum fetch-to-decode latency 2 cycles after issue).
REQ-017 Simultaneous push and pop SHALL leave count unchanged and preserve order; push when full SHALL be impossible by REQ-013 and asserted in simulation.
REQ-018 redirect_valid=1 (highest priority) SHALL in that cycle: suppress validPC, discard any arriving validInst, clear the FIFO (count<=0), set inflight<=0, and set pc<=redirect_pc; fetch from the new pc SHALL issue the next cycle.
REQ-019 Pop and redirect in the same cycle: the popped entry SHALL be considered delivered; the FIFO is still cleared.
REQ-020 Steady state with out_ready=1 SHALL sustain one instruction per cycle.
REQ-021 FAULT SHALL issue nothing and hold fetch_fault=1; only an aligned redirect SHALL return the FSM to RUN.

Reset
REQ-022 While rst=0: state<=BOOT, pc<=RESET_PC, count<=0, inflight<=0; validPC=0, out_valid=0, fetch_fault=0, out_pc=0 and out_inst=0 (outputs forced, not merely registered).
REQ-023 Reset asserted mid-operation SHALL discard any in-flight response arriving in the cycle after reset is asserted.

Configuration
REQ-024 Macro IFU_MISALIGN_FAULT_EN: when defined, a redirect with redirect_pc[1:0]!=0 SHALL enter FAULT with pc<=redirect_pc and fetch_fault=1.
REQ-025 When IFU_MISALIGN_FAULT_EN is undefined: FAULT SHALL be unreachable, fetch_fault SHALL be tied 0, and pc<={redirect_pc[31:2],2'b00}.

Verification
REQ-026 Reset release, out_ready=1, memory returns inst=pc^32'h1234 -> first validPC cycle 2 after rst rises with pc=8000_0000; out stream 8000_0000, 8000_0004, 8000_0008 at one per cycle.
REQ-027 Hold out_ready=0 for 10 cycles -> exactly 2 requests issued, FIFO full, validPC=0; release -> entries drain in order with no loss or duplicate.
REQ-028 Redirect to 8000_0100 on a cycle where validInst=1 -> that response dropped, FIFO empty next cycle, next validPC has pc=8000_0100, next output out_pc=8000_0100.
REQ-029 Redirect coincident with pop of 8000_0004 -> 8000_0004 counted delivered once; nothing else from the old path appears.
REQ-030 IFU_MISALIGN_FAULT_EN defined, redirect to 8000_0102 -> fetch_fault=1, validPC stays 0; redirect to 8000_0200 -> fault clears and fetch resumes. Undefined: same stimulus -> fetch from 8000_0100.
REQ-031 pc=FFFF_FFF8 start via redirect -> outputs FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with a two-entry output buffer.
//
// Issues sequential fetch requests to an instruction memory that has no
// backpressure and answers exactly one cycle after each accepted request.
// A request is only issued when its response is guaranteed a buffer slot.
// Buffered {pc, inst} pairs are handed to decode over a valid/ready channel.
// A downstream redirect flushes the buffer and restarts fetch at a new pc.
//
// Optional feature macro: IFU_MISALIGN_FAULT_EN
//   defined   : a redirect to a non-word-aligned pc enters FAULT and raises
//               fetch_fault until an aligned redirect arrives.
//   undefined : redirect targets are forced word aligned; FAULT unreachable.
//
// Ports
//   clk            in   sole clock, posedge
//   rst            in   synchronous active-low reset
//   validPC        out  fetch request to instruction memory
//   pc             out  fetch address (meaningful when validPC=1)
//   validInst      in   memory response valid (one cycle after request)
//   inst           in   instruction word
//   out_valid      out  decode channel valid
//   out_ready      in   decode channel ready
//   out_pc         out  pc of buffer head
//   out_inst       out  instruction of buffer head
//   redirect_valid in   branch/jump/trap redirect
//   redirect_pc    in   redirect target
//   fetch_fault    out  misaligned-redirect fault flag

module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        validPC,
  output logic [31:0] pc,
  input  logic        validInst,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_rsp_pc;
  logic        r_inflight;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_fifo_pc   [0:1];
  logic [31:0] r_fifo_inst [0:1];

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic        w_tail;
  logic        w_fault_st;
  logic        w_redir_misaligned;
  logic [31:0] w_redir_target;

`ifdef IFU_MISALIGN_FAULT_EN
  assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_redir_target     = redirect_pc;
`else
  assign w_redir_misaligned = 1'b0;
  assign w_redir_target     = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign out_valid = rst & (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  // Slots that will be occupied after this cycle's pop, counting the
  // response still in flight; a new request needs one slot left over.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = rst & (r_state == ST_RUN) & ~redirect_valid
                     & (w_occ < 3'(BUF_DEPTH));
  assign w_push    = rst & validInst & r_inflight & ~redirect_valid;
  // Tail slot is head offset by occupancy; a full buffer never pushes.
  assign w_tail    = r_head ^ r_count[0];

  assign validPC     = w_issue;
  assign pc          = r_pc;
  assign out_pc      = rst ? r_fifo_pc[r_head]   : 32'h0000_0000;
  assign out_inst    = rst ? r_fifo_inst[r_head] : 32'h0000_0000;
  assign fetch_fault = rst & w_fault_st;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; redirects override the boot/run progression
  always_comb begin
    w_state_nxt = r_state;
    w_fault_st  = 1'b0;
    case (r_state)
      ST_BOOT, ST_RUN: begin
        if (redirect_valid && w_redir_misaligned) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_fault_st = 1'b1;
        if (redirect_valid && !w_redir_misaligned) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Fetch pointer, in-flight tracking and buffer occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= 32'h0000_0000;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= w_redir_target;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + 32'd4;
        r_rsp_pc <= r_pc;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  // Buffer storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fifo_pc[0]   <= 32'h0000_0000;
      r_fifo_pc[1]   <= 32'h0000_0000;
      r_fifo_inst[0] <= 32'h0000_0000;
      r_fifo_inst[1] <= 32'h0000_0000;
    end else if (w_push) begin
      r_fifo_pc[w_tail]   <= r_rsp_pc;
      r_fifo_inst[w_tail] <= inst;
    end
  end

  ifu_fetch_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .count (r_count)
  );

endmodule

// ifu_fetch_chk: buffer occupancy properties for ifu_fetch.
// Ports: clk, rst (active-low), push strobe, current count.
module ifu_fetch_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic [1:0] count
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == 2'd2)));

  a_count_bounded: assert property (@(posedge clk) disable iff (!rst)
    (count <= 2'd2));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_MISALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validPC;
  logic [31:0] pc;
  logic        validInst = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  ifu_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .validPC(validPC), .pc(pc),
    .validInst(validInst), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch mode (0 boot, 1 run, 2 fault), next fetch pc,
  // outstanding request, and the ordered list of buffered {pc, inst}.
  int          m_mode = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_rsp_pc = 32'h0;
  bit          m_infl = 1'b0;
  logic [63:0] m_q[$];

  // Memory: answers the previous cycle's accepted request.
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  // Observations of the DUT for the directed literal checks.
  int          cyc = 0;
  int          n_issue = 0;
  int          first_vpc = -1;
  logic [31:0] first_vpc_pc = 32'h0;
  logic [31:0] d_pc[$];
  int          d_cyc[$];
  bit          s_vpc, s_ov, s_ff;
  logic [31:0] s_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit rdv,
                      input logic [31:0] rpc, input bit spur);
    bit          e_vpc, e_ov, e_ff, e_pop;
    logic [31:0] e_opc, e_oinst, issued_pc;
    int          occ;
    rst = r;
    out_ready = rdy;
    redirect_valid = rdv;
    redirect_pc = rpc;
    if (mem_pend) begin
      validInst = 1'b1;
      inst = mem_addr ^ 32'h0000_1234;
    end else if (spur) begin
      validInst = 1'b1;
      inst = $urandom;
    end else begin
      validInst = 1'b0;
      inst = $urandom;
    end
    e_ov   = r && (m_q.size() != 0);
    e_pop  = e_ov && rdy;
    occ    = m_q.size() + int'(m_infl) - int'(e_pop);
    e_vpc  = r && (m_mode == 1) && !rdv && (occ < 2);
    e_ff   = r && (m_mode == 2);
    e_opc  = e_ov ? m_q[0][63:32] : 32'h0;
    e_oinst = e_ov ? m_q[0][31:0] : 32'h0;
    issued_pc = m_pc;

    @(negedge clk);
    chk("validPC", {31'h0, validPC}, {31'h0, e_vpc});
    if (e_vpc) chk("pc", pc, m_pc);
    chk("out_valid", {31'h0, out_valid}, {31'h0, e_ov});
    if (e_ov || !r) begin
      chk("out_pc", out_pc, e_opc);
      chk("out_inst", out_inst, e_oinst);
    end
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, e_ff});
    if (validPC) begin
      n_issue++;
      if (first_vpc < 0) begin
        first_vpc = cyc;
        first_vpc_pc = pc;
      end
    end
    if (out_valid && out_ready) begin
      d_pc.push_back(out_pc);
      d_cyc.push_back(cyc);
    end
    s_vpc = validPC;
    s_pc = pc;
    s_ov = out_valid;
    s_ff = fetch_fault;

    @(posedge clk);
    if (!r) begin
      m_mode = 0;
      m_pc = RESET_PC;
      m_q.delete();
      m_infl = 1'b0;
    end else if (rdv) begin
      m_q.delete();
      m_infl = 1'b0;
      if (FAULT_EN && (rpc[1:0] != 2'b00)) begin
        m_mode = 2;
        m_pc = rpc;
      end else begin
        m_mode = 1;
        m_pc = {rpc[31:2], 2'b00};
      end
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (validInst && m_infl) m_q.push_back({m_rsp_pc, inst});
      if (e_vpc) begin
        m_rsp_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
      m_infl = e_vpc;
      if (m_mode == 0) m_mode = 1;
    end
    mem_pend = e_vpc;
    mem_addr = issued_pc;
    cyc++;
    #1;
  endtask

  initial begin
    int b, rel, iss0;
    logic [31:0] rpc;
    #1;

    // Reset, then stream from RESET_PC with decode always ready
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    first_vpc = -1;
    rel = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("first_vpc_delay", first_vpc - rel, 32'd1);
    chk("first_vpc_pc", first_vpc_pc, 32'h8000_0000);
    chk("boot_out0", d_pc[0], 32'h8000_0000);
    chk("boot_out1", d_pc[1], 32'h8000_0004);
    chk("boot_out2", d_pc[2], 32'h8000_0008);
    chk("boot_lat", d_cyc[0] - rel, 32'd3);
    chk("boot_rate1", d_cyc[1] - d_cyc[0], 32'd1);
    chk("boot_rate2", d_cyc[2] - d_cyc[1], 32'd1);

    // Backpressure: decode stalled for 10 cycles after a fresh redirect
    step(1'b1, 1'b0, 1'b1, 32'h8000_0040, 1'b0);
    iss0 = n_issue;
    b = d_pc.size();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_issues", n_issue - iss0, 32'd2);
    chk("stall_vpc", {31'h0, s_vpc}, 32'd0);
    chk("stall_full", {31'h0, s_ov}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain0", d_pc[b], 32'h8000_0040);
    chk("drain1", d_pc[b+1], 32'h8000_0044);
    chk("drain2", d_pc[b+2], 32'h8000_0048);

    // Redirect coincident with a response and with the pop of 8000_0004
    b = d_pc.size();
    step(1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_empty", {31'h0, s_ov}, 32'd0);
    chk("redir_vpc", {31'h0, s_vpc}, 32'd1);
    chk("redir_pc", s_pc, 32'h8000_0100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_d1", d_pc[b+1], 32'h8000_0000);
    chk("redir_d2", d_pc[b+2], 32'h8000_0004);
    chk("redir_d3", d_pc[b+3], 32'h8000_0100);

    // Misaligned redirect
    step(1'b1, 1'b1, 1'b1, 32'h8000_0102, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef IFU_MISALIGN_FAULT_EN
    chk("mis_fault", {31'h0, s_ff}, 32'd1);
    chk("mis_vpc", {31'h0, s_vpc}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_hold", {31'h0, s_ff}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_clear", {31'h0, s_ff}, 32'd0);
    chk("mis_resume", {31'h0, s_vpc}, 32'd1);
    chk("mis_resume_pc", s_pc, 32'h8000_0200);
`else
    chk("mis_nofault", {31'h0, s_ff}, 32'd0);
    chk("mis_vpc", {31'h0, s_vpc}, 32'd1);
    chk("mis_pc", s_pc, 32'h8000_0100);
`endif

    // Address wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    b = d_pc.size();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap0", d_pc[b], 32'hFFFF_FFF8);
    chk("wrap1", d_pc[b+1], 32'hFFFF_FFFC);
    chk("wrap2", d_pc[b+2], 32'h0000_0000);

    // Reset in the middle of streaming with a response in flight
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_ov", {31'h0, s_ov}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_boot", {31'h0, s_vpc}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_vpc", {31'h0, s_vpc}, 32'd1);
    chk("midrst_pc", s_pc, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) rpc = rpc + 32'($urandom_range(1, 3));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
